// File: rtl/vlsu_pkg.sv
// vlsu_pkg: meta types shared by the VLSU control machine, meta buffer and data controllers
package vlsu_pkg;
  typedef logic [15:0] meta_glb_t;
  typedef logic [7:0]  meta_seglv_t;
  typedef struct packed {
    meta_glb_t   glb;
    meta_seglv_t seglv;
  } meta_entry_t;
endpackage

// File: rtl/vlsu_meta_buffer.sv
// vlsu_meta_buffer: per-segment meta FIFO between the VLSU control machine and the data controllers
module vlsu_meta_buffer
  import vlsu_pkg::*;
#(
  parameter int Depth = 4,
  localparam int CntW = $clog2(Depth + 1),
  localparam int PtrW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            enq_valid_i,
  output logic            enq_ready_o,
  input  meta_glb_t       enq_glb_i,
  input  meta_seglv_t     enq_seglv_i,
  output logic            deq_valid_o,
  input  logic            deq_ready_i,
  output meta_glb_t       deq_glb_o,
  output meta_seglv_t     deq_seglv_o,
  output logic [CntW-1:0] usage_o,
  output logic            empty_o,
  output logic            full_o
);
  meta_entry_t     mem [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] cnt;
  logic            enq_fire, deq_fire;
  assign enq_ready_o = cnt != CntW'(Depth);
  assign deq_valid_o = cnt != '0;
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign deq_fire    = deq_valid_o & deq_ready_i;
  assign usage_o     = cnt;
  assign empty_o     = !deq_valid_o;
  assign full_o      = !enq_ready_o;
  // Head is gated so an empty buffer presents zeros instead of stale array contents.
  assign {deq_glb_o, deq_seglv_o} = deq_valid_o ? mem[rd_ptr] : '0;
  always_ff @(posedge clk_i)
    if (enq_fire && !flush_i) mem[wr_ptr] <= '{glb: enq_glb_i, seglv: enq_seglv_i};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr == PtrW'(Depth - 1) ? '0 : wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr == PtrW'(Depth - 1) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CntW'(enq_fire) - CntW'(deq_fire);
    end
  end
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (rst_i) enq_fire |-> cnt != CntW'(Depth));
  a_no_deq_empty: assert property (@(posedge clk_i) disable iff (rst_i) deq_fire |-> cnt != '0);
  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i) int'(cnt) <= Depth);
  a_ptr_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt == CntW'(Depth) || int'(cnt) == (int'(wr_ptr) + Depth - int'(rd_ptr)) % Depth);
endmodule

// File: tb/tb_vlsu_meta_buffer.sv
// tb_vlsu_meta_buffer: directed and random traffic checked against a queue-based FIFO model
module tb_vlsu_meta_buffer;
  import vlsu_pkg::*;
  localparam int DEPTH = 4;
  logic        clk_i = 0, rst_i = 1, flush_i = 0;
  logic        enq_valid_i = 1, enq_ready_o, deq_valid_o, deq_ready_i = 0;
  meta_glb_t   enq_glb_i = '0, deq_glb_o;
  meta_seglv_t enq_seglv_i = '0, deq_seglv_o;
  logic [2:0]  usage_o;
  logic        empty_o, full_o;
  int          checks = 0, failures = 0;
  meta_entry_t exp_q [$];

  vlsu_meta_buffer #(.Depth(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_glb_i(enq_glb_i), .enq_seglv_i(enq_seglv_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_glb_o(deq_glb_o), .deq_seglv_o(deq_seglv_o),
    .usage_o(usage_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference FIFO: accepts while it holds fewer than DEPTH entries, flush or reset empties it.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) exp_q.delete();
    else begin
      automatic bit d = deq_ready_i && exp_q.size() != 0;
      automatic bit e = enq_valid_i && exp_q.size() != DEPTH;
      if (d) void'(exp_q.pop_front());
      if (e) exp_q.push_back({enq_glb_i, enq_seglv_i});
    end
  end

  // Monitor: status every cycle, head contents whenever an entry is presented.
  always @(negedge clk_i) begin
    chk("usage", int'(usage_o), exp_q.size());
    chk("empty", int'(empty_o), int'(exp_q.size() == 0));
    chk("full", int'(full_o), int'(exp_q.size() == DEPTH));
    chk("enq_ready", int'(enq_ready_o), int'(exp_q.size() != DEPTH));
    chk("deq_valid", int'(deq_valid_o), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("deq_glb", int'(deq_glb_o), int'(exp_q[0].glb));
      chk("deq_seglv", int'(deq_seglv_o), int'(exp_q[0].seglv));
    end
    if (rst_i) begin
      chk("rst_glb", int'(deq_glb_o), 0);
      chk("rst_seglv", int'(deq_seglv_o), 0);
    end
  end

  task automatic cyc(input bit ev, input meta_glb_t g, input meta_seglv_t s, input bit dr, input bit fl = 0);
    enq_valid_i = ev; enq_glb_i = g; enq_seglv_i = s; deq_ready_i = dr; flush_i = fl;
    @(posedge clk_i); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    for (int i = 0; i < 5; i++) cyc(1, 16'(100 + i), 8'(i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(1, 16'h0a0a, 8'd20, 0);
    cyc(1, 16'h0b0b, 8'd21, 0);
    for (int i = 0; i < 10; i++) cyc(1, 16'(200 + i), 8'(30 + i), 1);
    for (int i = 0; i < 4; i++) cyc(1, 16'(300 + i), 8'(50 + i), 0);
    cyc(1, 16'h0c0c, 8'd60, 1);
    cyc(1, 16'h0d0d, 8'd61, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 16'h0e0e, 8'd62, 1, 1);
    cyc(1, 16'h0707, 8'd7, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_i = 1;
        cyc(1, 16'($urandom), 8'($urandom), 1);
        rst_i = 0;
      end
      cyc($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    cyc(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
